lsu_ctrl_riscv: RTL and testbench
=================================

Name: lsu_ctrl_riscv

Overview:
Load/store unit controller sitting between the instruction decoder and the data-memory port. It accepts the decoder's mem_req/mem_we/mem_size and the ALU-computed address, and sequences a request/grant/rvalid transaction on the data bus. It generates byte enables and store-data replication, and extracts plus sign- or zero-extends load data. It stalls the core until the access completes and flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before abort; 0 disables the timeout.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
lsu_req_i  in  1  access request from decoder (mem_req_o); held high while the core is stalled
lsu_we_i  in  1  1 = store, 0 = load
lsu_size_i  in  3  funct3 size code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU
lsu_addr_i  in  32  byte address (ALU result)
lsu_data_i  in  32  store data (rs2)
lsu_data_o  out  32  extended load result
lsu_stall_req_o  out  1  core stall request
lsu_misalign_o  out  1  misaligned access flag
lsu_timeout_o  out  1  bus timeout pulse
data_req_o  out  1  bus request
data_we_o  out  1  bus write enable
data_be_o  out  4  byte enables
data_addr_o  out  32  word-aligned bus address
data_wdata_o  out  32  bus write data
data_gnt_i  in  1  request accepted
data_rvalid_i  in  1  read data valid
data_rdata_i  in  32  read data

Behaviour:
- One clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - state = IDLE, timeout counter = 0, all latched fields = 0.
  - All outputs are 0: data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_data_o, lsu_timeout_o, lsu_misalign_o, lsu_stall_req_o.
  - Reset mid-transaction abandons the access; data_req_o drops immediately.
- Size decode: codes 3, 6 and 7 are treated as B (the decoder already raises illegal_instr for them).
- Misalignment rule:
  - misaligned = (H or HU) & addr[0], or W & (addr[1:0] != 0).
  - Combinational: lsu_misalign_o = lsu_req_i & misaligned & (state == IDLE).
- Stall (combinational): lsu_stall_req_o = lsu_req_i & !misaligned & (state != DONE).
- FSM states and transitions:
  - IDLE: if lsu_req_i & !misaligned, latch addr, we, size and wdata, clear the counter, go to REQ. A misaligned request stays in IDLE with no bus activity and no stall.
  - REQ: data_req_o = 1 and all bus outputs are driven from the latched fields and held stable until data_gnt_i. On gnt: a store goes to DONE; a load goes to WAIT.
  - WAIT: data_req_o = 0. On data_rvalid_i, register the extracted load value into lsu_data_o and go to DONE. rvalid is never expected in the grant cycle; if seen outside WAIT it is ignored.
  - DONE: stall is low for exactly one cycle so the core advances. Unconditionally return to IDLE. A new lsu_req_i is only accepted from IDLE, so back-to-back accesses are spaced by at least one IDLE cycle.
  - Timeout: the counter increments each cycle in REQ or WAIT. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), pulse lsu_timeout_o for 1 cycle, set lsu_data_o = 0, go to DONE. The counter saturates and never wraps.
- Bus outputs:
  - data_addr_o = {addr[31:2], 2'b00}.
  - data_be_o: B = 4'b0001 << addr[1:0]; H = 4'b0011 << {addr[1], 1'b0}; W = 4'b1111.
  - data_wdata_o: B = {4{d[7:0]}}; H = {2{d[15:0]}}; W = d.
  - data_we_o = latched we during REQ.
  - All bus outputs are 0 outside REQ.
- Load extraction:
  - B/BU take byte addr[1:0]; H/HU take halfword addr[1]; W takes the whole word.
  - B and H are sign-extended; BU and HU are zero-extended.
- lsu_data_o holds its value until the next completed load, a timeout, or reset.
- Minimum latency: store 3 cycles (REQ with immediate gnt, DONE); load 4 cycles (IDLE→REQ, gnt, rvalid, DONE).

Test Plan:
- LB at addr 0x103, rdata 0x80FF_0000, gnt same cycle, rvalid the next cycle -> be = 4'b1000, data_addr_o = 0x100, lsu_data_o = 0xFFFF_FF80, stall high 3 cycles then low 1 cycle.
- LHU at 0x202, rdata 0xBEEF_1234 -> be = 4'b1100, lsu_data_o = 0x0000_BEEF. The same access as LH -> lsu_data_o = 0xFFFF_BEEF.
- SB at 0x001, data 0x1234_56AB, gnt delayed 3 cycles -> data_wdata_o = 0xABAB_ABAB and be = 4'b0010, all held stable until gnt, data_we_o = 1; DONE on the cycle after gnt.
- SW at 0x006 -> lsu_misalign_o = 1, stall = 0, data_req_o never asserted. LH at 0x005 gives the same response.
- TIMEOUT_CYCLES = 4, load with gnt but no rvalid -> lsu_timeout_o pulses once, lsu_data_o = 0, FSM returns to IDLE.
- rst_i asserted in WAIT -> outputs go to 0 immediately; a later rvalid is ignored and the next LW completes normally.

Source files
------------

// File: rtl/lsu_ctrl_riscv.sv
// Load/store unit controller: sequences one req/gnt/rvalid data-bus access per
// decoder request, forms byte enables and replicated store data, extracts and
// extends load data, stalls the core until completion and aborts on bus timeout.
module lsu_ctrl_riscv #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic        lsu_timeout_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    // Counter only needs to reach TIMEOUT_CYCLES; with the timeout disabled it is a dummy bit.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntSat =
        (TIMEOUT_CYCLES == 0) ? {CntW{1'b1}} : CntW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } state_e;

    state_e            r_state;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_ldata;
    logic              r_we;
    logic [2:0]        r_size;
    logic [CntW-1:0]   r_cnt;
    logic              r_timeout;

    logic              w_in_half;
    logic              w_in_word;
    logic              w_misaligned;
    logic              w_l_half;
    logic              w_l_word;
    logic              w_l_uns;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_ext;
    logic [CntW-1:0]   w_cnt_inc;
    logic              w_cnt_hit;
    logic              w_in_req;

    // Decode size/alignment of the incoming request; codes 3, 6, 7 fall through to byte.
    always_comb begin
        w_in_half    = (lsu_size_i == 3'd1) || (lsu_size_i == 3'd5);
        w_in_word    = (lsu_size_i == 3'd2);
        w_misaligned = (w_in_half & lsu_addr_i[0]) |
                       (w_in_word & (lsu_addr_i[1:0] != 2'b00));
    end

    // Byte enables and lane-replicated store data from the latched access.
    always_comb begin
        w_l_half = (r_size == 3'd1) || (r_size == 3'd5);
        w_l_word = (r_size == 3'd2);
        w_l_uns  = (r_size == 3'd4) || (r_size == 3'd5);
        w_be     = 4'b0000;
        w_wdata  = 32'h0;
        if (w_l_word) begin
            w_be    = 4'b1111;
            w_wdata = r_wdata;
        end else if (w_l_half) begin
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_wdata[15:0]}};
        end else begin
            w_be    = 4'b0001 << r_addr[1:0];
            w_wdata = {4{r_wdata[7:0]}};
        end
    end

    // Select the addressed lane of read data and sign/zero extend it.
    always_comb begin
        w_byte = 8'h0;
        unique case (r_addr[1:0])
            2'd0:    w_byte = data_rdata_i[7:0];
            2'd1:    w_byte = data_rdata_i[15:8];
            2'd2:    w_byte = data_rdata_i[23:16];
            default: w_byte = data_rdata_i[31:24];
        endcase
        w_half = r_addr[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        if (w_l_word) begin
            w_load_ext = data_rdata_i;
        end else if (w_l_half) begin
            w_load_ext = {{16{~w_l_uns & w_half[15]}}, w_half};
        end else begin
            w_load_ext = {{24{~w_l_uns & w_byte[7]}}, w_byte};
        end
    end

    // Saturating busy-cycle counter; hit means this cycle is the TIMEOUT_CYCLES-th in REQ+WAIT.
    always_comb begin
        w_cnt_inc = (r_cnt == CntSat) ? r_cnt : r_cnt + 1'b1;
        w_cnt_hit = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CntSat);
    end

    // Access sequencer: latches the request, tracks bus handshake, registers results.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_ldata   <= 32'h0;
            r_we      <= 1'b0;
            r_size    <= 3'd0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (lsu_req_i && !w_misaligned) begin
                        r_addr  <= lsu_addr_i;
                        r_we    <= lsu_we_i;
                        r_size  <= lsu_size_i;
                        r_wdata <= lsu_data_i;
                        r_cnt   <= '0;
                        r_state <= StReq;
                    end
                end
                StReq: begin
                    r_cnt <= w_cnt_inc;
                    // A granted store completes; a granted load still needs rvalid,
                    // so the timeout wins over it.
                    if (data_gnt_i && r_we) begin
                        r_state <= StDone;
                    end else if (w_cnt_hit) begin
                        r_timeout <= 1'b1;
                        r_ldata   <= 32'h0;
                        r_state   <= StDone;
                    end else if (data_gnt_i) begin
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    r_cnt <= w_cnt_inc;
                    if (data_rvalid_i) begin
                        r_ldata <= w_load_ext;
                        r_state <= StDone;
                    end else if (w_cnt_hit) begin
                        r_timeout <= 1'b1;
                        r_ldata   <= 32'h0;
                        r_state   <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign w_in_req     = (r_state == StReq);
    assign data_req_o   = w_in_req;
    assign data_we_o    = w_in_req & r_we;
    assign data_be_o    = w_in_req ? w_be : 4'b0000;
    assign data_addr_o  = w_in_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign data_wdata_o = w_in_req ? w_wdata : 32'h0;

    assign lsu_data_o    = r_ldata;
    assign lsu_timeout_o = r_timeout;
    // Gated by reset so every output reads 0 while reset is held.
    assign lsu_stall_req_o = ~rst_i & lsu_req_i & ~w_misaligned & (r_state != StDone);
    assign lsu_misalign_o  = ~rst_i & lsu_req_i & w_misaligned & (r_state == StIdle);

endmodule

// File: tb/tb_lsu_ctrl_riscv.sv
// Bench for lsu_ctrl_riscv: transaction-level model predicts every output per cycle.
module tb_lsu_ctrl_riscv;

    localparam int unsigned T = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_data_i;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o, lsu_misalign_o, lsu_timeout_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i;
    logic [31:0] data_rdata_i;

    lsu_ctrl_riscv #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_data_i     (lsu_data_i),
        .lsu_data_o     (lsu_data_o),
        .lsu_stall_req_o(lsu_stall_req_o),
        .lsu_misalign_o (lsu_misalign_o),
        .lsu_timeout_o  (lsu_timeout_o),
        .data_req_o     (data_req_o),
        .data_we_o      (data_we_o),
        .data_be_o      (data_be_o),
        .data_addr_o    (data_addr_o),
        .data_wdata_o   (data_wdata_o),
        .data_gnt_i     (data_gnt_i),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    // Expected outputs for the current cycle.
    logic        e_stall, e_mis, e_to, e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_data;
    logic [31:0] m_data = 32'h0;

    // Observations used by the literal checks.
    int          obs_req_cnt = 0, obs_stall_hi = 0, obs_to_cnt = 0, obs_mis_cnt = 0;
    logic [3:0]  obs_be = 4'h0;
    logic [31:0] obs_addr = 32'h0, obs_wdata = 32'h0;
    logic        obs_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        chk("stall", 32'(lsu_stall_req_o), 32'(e_stall));
        chk("misalign", 32'(lsu_misalign_o), 32'(e_mis));
        chk("timeout", 32'(lsu_timeout_o), 32'(e_to));
        chk("data_req", 32'(data_req_o), 32'(e_req));
        chk("data_we", 32'(data_we_o), 32'(e_we));
        chk("data_be", 32'(data_be_o), 32'(e_be));
        chk("data_addr", data_addr_o, e_addr);
        chk("data_wdata", data_wdata_o, e_wdata);
        chk("lsu_data", lsu_data_o, e_data);
        if (data_req_o) begin
            obs_req_cnt++;
            obs_be    = data_be_o;
            obs_addr  = data_addr_o;
            obs_wdata = data_wdata_o;
            obs_we    = data_we_o;
        end
        if (lsu_stall_req_o) obs_stall_hi++;
        if (lsu_timeout_o) obs_to_cnt++;
        if (lsu_misalign_o) obs_mis_cnt++;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lsu_data"}, lsu_data_o, 32'h0);
        chk({tag, "_stall"}, 32'(lsu_stall_req_o), 32'h0);
        chk({tag, "_misalign"}, 32'(lsu_misalign_o), 32'h0);
        chk({tag, "_timeout"}, 32'(lsu_timeout_o), 32'h0);
        chk({tag, "_req"}, 32'(data_req_o), 32'h0);
        chk({tag, "_we"}, 32'(data_we_o), 32'h0);
        chk({tag, "_be"}, 32'(data_be_o), 32'h0);
        chk({tag, "_addr"}, data_addr_o, 32'h0);
        chk({tag, "_wdata"}, data_wdata_o, 32'h0);
    endtask

    // 0 = byte, 1 = halfword, 2 = word
    function automatic int cls_of(input logic [2:0] s);
        if (s == 3'd1 || s == 3'd5) return 1;
        if (s == 3'd2) return 2;
        return 0;
    endfunction

    function automatic logic [3:0] exp_be(input int c, input logic [31:0] a);
        int lane = int'(a % 32'd4);
        if (c == 2) return 4'hF;
        if (c == 1) return 4'(3 << (lane & 2));
        return 4'(1 << lane);
    endfunction

    function automatic logic [31:0] exp_wdata(input int c, input logic [31:0] d);
        if (c == 2) return d;
        if (c == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return (d & 32'hFF) * 32'h0101_0101;
    endfunction

    function automatic logic [31:0] exp_load(input int c, input logic uns, input logic [31:0] a,
                                             input logic [31:0] rd);
        int lane = int'(a % 32'd4);
        logic [31:0] v;
        if (c == 2) return rd;
        if (c == 1) begin
            v = (rd >> (8 * (lane & 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = (rd >> (8 * lane)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_bus_idle();
        e_req = 1'b0; e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
    endtask

    task automatic set_idle();
        set_bus_idle();
        e_stall = 1'b0; e_mis = 1'b0; e_to = 1'b0; e_data = m_data;
    endtask

    // One decoder access: gnt after g REQ cycles, rvalid r cycles after gnt (loads).
    task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input int g, input int r,
                             input logic [31:0] rd);
        int   c, need, n;
        logic uns, mis, ok;
        c   = cls_of(size);
        uns = (size == 3'd4) || (size == 3'd5);
        mis = (c == 1 && (addr % 32'd2) != 0) || (c == 2 && (addr % 32'd4) != 0);
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_addr_i = addr; lsu_data_i = wd;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        set_idle();
        e_stall = !mis; e_mis = mis;
        step();
        if (mis) begin
            lsu_req_i = 1'b0;
            set_idle();
            return;
        end
        need = we ? g + 1 : g + 1 + r;
        ok   = need <= int'(T);
        n    = ok ? need : int'(T);
        e_mis = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k <= g) begin
                e_req = 1'b1; e_we = we; e_be = exp_be(c, addr);
                e_addr = addr - (addr % 32'd4); e_wdata = exp_wdata(c, wd);
                data_gnt_i    = (k == g);
                data_rvalid_i = (k < g) && ($urandom_range(0, 3) == 0);
                data_rdata_i  = $urandom;
            end else begin
                set_bus_idle();
                data_gnt_i    = 1'b0;
                data_rvalid_i = (k == g + r);
                data_rdata_i  = (k == g + r) ? rd : $urandom;
            end
            e_stall = 1'b1;
            step();
        end
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        if (!ok) m_data = 32'h0;
        else if (!we) m_data = exp_load(c, uns, addr, rd);
        set_bus_idle();
        e_stall = 1'b0; e_to = !ok; e_data = m_data;
        step();
        lsu_req_i = 1'b0;
        set_idle();
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            data_rvalid_i = ($urandom_range(0, 1) == 0);
            data_rdata_i  = $urandom;
            set_idle();
            step();
        end
        data_rvalid_i = 1'b0;
    endtask

    initial begin
        int s0, r0, t0, m0;
        logic [2:0]  sz;
        logic [31:0] ad;
        rst_i = 1'b1;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0; lsu_addr_i = 32'h0;
        lsu_data_i = 32'h0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
        set_idle();
        fork
            forever begin
                @(negedge clk_i);
                if (chk_en) cmp_cycle();
            end
        join_none

        #2;
        chk_all_zero("reset");
        step();
        rst_i = 1'b0;
        chk_en = 1'b1;
        idle_gap(2);

        // LB 0x103
        s0 = obs_stall_hi;
        do_access(1'b0, 3'd0, 32'h103, 32'h0, 0, 1, 32'h80FF_0000);
        chk("lb_be", 32'(obs_be), 32'h8);
        chk("lb_addr", obs_addr, 32'h100);
        chk("lb_data", lsu_data_o, 32'hFFFF_FF80);
        chk("lb_stall_cycles", 32'(obs_stall_hi - s0), 32'd3);

        // LHU / LH 0x202
        do_access(1'b0, 3'd5, 32'h202, 32'h0, 0, 1, 32'hBEEF_1234);
        chk("lhu_be", 32'(obs_be), 32'hC);
        chk("lhu_data", lsu_data_o, 32'h0000_BEEF);
        do_access(1'b0, 3'd1, 32'h202, 32'h0, 0, 1, 32'hBEEF_1234);
        chk("lh_data", lsu_data_o, 32'hFFFF_BEEF);

        // Reset while in WAIT
        chk_en = 1'b0;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 3'd2; lsu_addr_i = 32'h40;
        step();
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        step();
        rst_i = 1'b0;
        lsu_req_i = 1'b0;
        m_data = 32'h0;
        data_rvalid_i = 1'b1;
        data_rdata_i = 32'hDEAD_BEEF;
        set_idle();
        chk_en = 1'b1;
        step();
        data_rvalid_i = 1'b0;
        do_access(1'b0, 3'd2, 32'h48, 32'h0, 1, 2, 32'h1357_9BDF);
        chk("lw_after_rst", lsu_data_o, 32'h1357_9BDF);

        // SB with gnt delayed 3 cycles
        r0 = obs_req_cnt;
        do_access(1'b1, 3'd0, 32'h001, 32'h1234_56AB, 3, 1, 32'h0);
        chk("sb_wdata", obs_wdata, 32'hABAB_ABAB);
        chk("sb_be", 32'(obs_be), 32'h2);
        chk("sb_we", 32'(obs_we), 32'h1);
        chk("sb_req_cycles", 32'(obs_req_cnt - r0), 32'd4);

        // Misaligned SW 0x006 and LH 0x005
        r0 = obs_req_cnt; s0 = obs_stall_hi; m0 = obs_mis_cnt;
        do_access(1'b1, 3'd2, 32'h006, 32'hCAFE_F00D, 0, 1, 32'h0);
        do_access(1'b0, 3'd1, 32'h005, 32'h0, 0, 1, 32'h0);
        chk("mis_req_cycles", 32'(obs_req_cnt - r0), 32'd0);
        chk("mis_stall_cycles", 32'(obs_stall_hi - s0), 32'd0);
        chk("mis_flag_cycles", 32'(obs_mis_cnt - m0), 32'd2);

        // Load granted but never answered
        t0 = obs_to_cnt;
        do_access(1'b0, 3'd2, 32'h20, 32'h0, 0, 1000, 32'h0);
        chk("to_pulses", 32'(obs_to_cnt - t0), 32'd1);
        chk("to_data", lsu_data_o, 32'h0);
        idle_gap(1);

        // Randomized accesses
        for (int i = 0; i < 300; i++) begin
            sz = 3'($urandom_range(0, 7));
            ad = $urandom;
            if ($urandom_range(0, 9) < 8) ad = ad - (ad % 32'd4) + (ad % 32'd4) * 32'(cls_of(sz) == 0);
            do_access(1'($urandom_range(0, 1)), sz, ad, $urandom,
                      $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(1, 3),
                      $urandom);
            idle_gap($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
